// File: rtl/corr_pkg.sv
// Shared types and width helpers for the correlation window accumulator.
// Default-configuration typedefs; parameterised users derive widths via corr_acc_w().
package corr_pkg;

  localparam int DEF_PIXEL_SIZE    = 8;
  localparam int DEF_LINE_SIZE     = 8;
  localparam int DEF_NUM_TEMPLATES = 4;
  localparam int DEF_NUM_LINES     = 8;

  // Accumulator width large enough that LINE_SIZE*NUM_LINES products never wrap
  function automatic int corr_acc_w(input int pixel_size, input int line_size, input int num_lines);
    return 2 * pixel_size + $clog2(line_size * num_lines);
  endfunction

  // Width of a single reduced line
  function automatic int corr_line_w(input int pixel_size, input int line_size);
    return 2 * pixel_size + $clog2(line_size);
  endfunction

  localparam int CORR_ACC_W = corr_acc_w(DEF_PIXEL_SIZE, DEF_LINE_SIZE, DEF_NUM_LINES);

  typedef logic [CORR_ACC_W-1:0] acc_t;

  typedef struct packed {
    acc_t                               sum_I;
    acc_t                               sum_I2;
    logic [DEF_NUM_TEMPLATES-1:0][CORR_ACC_W-1:0] sum_TI;
  } window_sums_t;

endpackage

// File: rtl/line_adder_tree.sv
// Combinational unsigned adder tree reducing N words of IN_W bits.
// Output is IN_W + $clog2(N) bits wide, so the sum can never wrap.
module line_adder_tree #(
  parameter int N         = 8,
  parameter int IN_W      = 16,
  localparam int OUT_W    = IN_W + $clog2(N)
) (
  input  logic [N-1:0][IN_W-1:0] in_data,
  output logic [OUT_W-1:0]       sum
);

  localparam int LEVELS = $clog2(N);
  localparam int P2     = 1 << LEVELS;

  logic [OUT_W-1:0] tree_s [LEVELS+1][P2];

  // Balanced pairwise reduction; leaves beyond N are padded with zero
  always_comb begin
    for (int l = 0; l <= LEVELS; l++) begin
      for (int i = 0; i < P2; i++) begin
        tree_s[l][i] = {OUT_W{1'b0}};
      end
    end
    for (int i = 0; i < N; i++) begin
      tree_s[0][i] = OUT_W'(in_data[i]);
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < (P2 >> (l + 1)); i++) begin
        tree_s[l+1][i] = tree_s[l][2*i] + tree_s[l][2*i+1];
      end
    end
  end

  assign sum = tree_s[LEVELS][0];

endmodule

// File: rtl/correlation_window_accumulator.sv
// Reduces per-pixel I, I^2 and T*I lines and accumulates NUM_LINES lines into window sums.
// Optional macro CORR_PIPE_EN inserts a register stage between the adder trees and the accumulator.
module correlation_window_accumulator
  import corr_pkg::*;
#(
  parameter int PIXEL_SIZE    = 8,
  parameter int LINE_SIZE     = 8,
  parameter int NUM_TEMPLATES = 4,
  parameter int NUM_LINES     = 8,
  localparam int ACC_W        = corr_acc_w(PIXEL_SIZE, LINE_SIZE, NUM_LINES)
) (
  input  logic                                              CLK,
  input  logic                                              RST_N,
  input  logic                                              clr,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [LINE_SIZE-1:0][2*PIXEL_SIZE-1:0]            I_square_in_line,
  input  logic [LINE_SIZE-1:0][2*PIXEL_SIZE-1:0]            I_in_line,
  input  logic [NUM_TEMPLATES-1:0][LINE_SIZE-1:0][2*PIXEL_SIZE-1:0] T_x_I_in_lines_transpose,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [ACC_W-1:0]                                  sum_I,
  output logic [ACC_W-1:0]                                  sum_I2,
  output logic [NUM_TEMPLATES-1:0][ACC_W-1:0]               sum_TI
);

  localparam int PROD_W = 2 * PIXEL_SIZE;
  localparam int LSUM_W = corr_line_w(PIXEL_SIZE, LINE_SIZE);
  localparam int CNT_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LINES - 1);

  typedef struct packed {
    logic [ACC_W-1:0]                    sum_I;
    logic [ACC_W-1:0]                    sum_I2;
    logic [NUM_TEMPLATES-1:0][ACC_W-1:0] sum_TI;
  } sums_t;

  logic [LSUM_W-1:0]                     line_i_s;
  logic [LSUM_W-1:0]                     line_i2_s;
  logic [NUM_TEMPLATES-1:0][LSUM_W-1:0]  line_ti_s;

  sums_t            line_sums_s;
  sums_t            feed_sums_s;
  sums_t            acc_next_s;
  sums_t            acc_r;
  sums_t            out_r;
  logic [CNT_W-1:0] line_cnt_r;
  logic             out_valid_r;
  logic             last_line_s;
  logic             accept_s;
  logic             feed_valid_s;
  logic             in_ready_s;

  line_adder_tree #(.N(LINE_SIZE), .IN_W(PROD_W)) u_tree_i (
    .in_data (I_in_line),
    .sum     (line_i_s)
  );

  line_adder_tree #(.N(LINE_SIZE), .IN_W(PROD_W)) u_tree_i2 (
    .in_data (I_square_in_line),
    .sum     (line_i2_s)
  );

  for (genvar t = 0; t < NUM_TEMPLATES; t++) begin : g_tree_ti
    line_adder_tree #(.N(LINE_SIZE), .IN_W(PROD_W)) u_tree_ti (
      .in_data (T_x_I_in_lines_transpose[t]),
      .sum     (line_ti_s[t])
    );
  end

  // Zero-extend each reduced line to accumulator width
  always_comb begin
    line_sums_s        = '0;
    line_sums_s.sum_I  = ACC_W'(line_i_s);
    line_sums_s.sum_I2 = ACC_W'(line_i2_s);
    for (int t = 0; t < NUM_TEMPLATES; t++) begin
      line_sums_s.sum_TI[t] = ACC_W'(line_ti_s[t]);
    end
  end

  assign last_line_s = (line_cnt_r == LAST_CNT);
  assign accept_s    = in_valid && in_ready_s;

`ifdef CORR_PIPE_EN
  logic  stage_valid_r;
  sums_t stage_sums_r;
  logic  stage_can_drain_s;

  // Staged line may enter the accumulator unless it would overwrite a held, undrained result
  assign stage_can_drain_s = !last_line_s || !out_valid_r || out_ready;
  assign in_ready_s        = RST_N && !clr && (!stage_valid_r || stage_can_drain_s);
  assign feed_valid_s      = stage_valid_r && stage_can_drain_s && !clr;
  assign feed_sums_s       = stage_sums_r;

  // Line register between the adder trees and the accumulator
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stage_valid_r <= 1'b0;
      stage_sums_r  <= '0;
    end else if (clr) begin
      stage_valid_r <= 1'b0;
    end else if (accept_s) begin
      stage_valid_r <= 1'b1;
      stage_sums_r  <= line_sums_s;
    end else if (feed_valid_s) begin
      stage_valid_r <= 1'b0;
    end
  end
`else
  // Stall only on the last line while the output register is full and not draining
  assign in_ready_s   = RST_N && !clr && !(last_line_s && out_valid_r && !out_ready);
  assign feed_valid_s = accept_s;
  assign feed_sums_s  = line_sums_s;
`endif

  // Running window sum including the line being fed this cycle
  always_comb begin
    acc_next_s        = '0;
    acc_next_s.sum_I  = acc_r.sum_I + feed_sums_s.sum_I;
    acc_next_s.sum_I2 = acc_r.sum_I2 + feed_sums_s.sum_I2;
    for (int t = 0; t < NUM_TEMPLATES; t++) begin
      acc_next_s.sum_TI[t] = acc_r.sum_TI[t] + feed_sums_s.sum_TI[t];
    end
  end

  // Accumulator and line counter; restart after the last line of each window
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_r      <= '0;
      line_cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      acc_r      <= '0;
      line_cnt_r <= {CNT_W{1'b0}};
    end else if (feed_valid_s) begin
      if (last_line_s) begin
        acc_r      <= '0;
        line_cnt_r <= {CNT_W{1'b0}};
      end else begin
        acc_r      <= acc_next_s;
        line_cnt_r <= line_cnt_r + CNT_W'(1);
      end
    end
  end

  // Output register: refill on window completion, otherwise drain on handshake
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else if (feed_valid_s && last_line_s) begin
      out_r       <= acc_next_s;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign sum_I     = out_r.sum_I;
  assign sum_I2    = out_r.sum_I2;
  assign sum_TI    = out_r.sum_TI;

endmodule

// File: tb/tb_correlation_window_accumulator.sv
// Scoreboard bench for correlation_window_accumulator (LINE_SIZE=4, 2 templates, 3 lines).
// Build with CORR_PIPE_EN defined to check the pipelined variant.
module tb_correlation_window_accumulator;

`ifdef CORR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [19:0] si;
    logic [19:0] si2;
    logic [19:0] t0;
    logic [19:0] t1;
  } exp_t;

  logic                   clk;
  logic                   rst_n;
  logic                   clr;
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0][15:0]       i2_line;
  logic [3:0][15:0]       i_line;
  logic [1:0][3:0][15:0]  ti_lines;
  logic                   out_valid;
  logic                   out_ready;
  logic [19:0]            sum_I;
  logic [19:0]            sum_I2;
  logic [1:0][19:0]       sum_TI;

  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_cnt    = 0;
  logic [19:0] m_i, m_i2, m_t0, m_t1;
  int          stalls_v;

  correlation_window_accumulator #(
    .PIXEL_SIZE    (8),
    .LINE_SIZE     (4),
    .NUM_TEMPLATES (2),
    .NUM_LINES     (3)
  ) dut (
    .CLK                      (clk),
    .RST_N                    (rst_n),
    .clr                      (clr),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .I_square_in_line         (i2_line),
    .I_in_line                (i_line),
    .T_x_I_in_lines_transpose (ti_lines),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .sum_I                    (sum_I),
    .sum_I2                   (sum_I2),
    .sum_TI                   (sum_TI)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_i = 20'd0; m_i2 = 20'd0; m_t0 = 20'd0; m_t1 = 20'd0;
  endtask

  // Drive one line (every pixel equal) and wait for it to be accepted
  task automatic send_line(input logic [15:0] vi, input logic [15:0] vi2,
                           input logic [15:0] vt0, input logic [15:0] vt1, output int stalls);
    logic acc;
    i_line   = {4{vi}};
    i2_line  = {4{vi2}};
    ti_lines = {{4{vt1}}, {4{vt0}}};
    in_valid = 1'b1;
    stalls   = 0;
    acc      = 1'b0;
    while (!acc && stalls < 50) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      chk("accept_timeout", 0, 1);
    end else begin
      m_i  = m_i  + 20'(vi)  * 20'd4;
      m_i2 = m_i2 + 20'(vi2) * 20'd4;
      m_t0 = m_t0 + 20'(vt0) * 20'd4;
      m_t1 = m_t1 + 20'(vt1) * 20'd4;
      m_cnt++;
      if (m_cnt == 3) begin
        exp_q.push_back('{si: m_i, si2: m_i2, t0: m_t0, t1: m_t1});
        model_clear();
      end
    end
  endtask

  // Monitor: compare every output handshake, and check held data stays stable
  initial begin
    exp_t        e;
    logic        hold_prev;
    logic [79:0] prev_data;
    hold_prev = 1'b0;
    prev_data = 80'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", ({sum_I, sum_I2, sum_TI} == prev_data), 1);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sum_I", sum_I, e.si);
            chk("sum_I2", sum_I2, e.si2);
            chk("sum_TI0", sum_TI[0], e.t0);
            chk("sum_TI1", sum_TI[1], e.t1);
          end
        end
        hold_prev = out_valid && !out_ready;
        prev_data = {sum_I, sum_I2, sum_TI};
      end
    end
  end

  initial begin
    logic [15:0] bp_tab [9][4];
    int          lat;
    int          w;
    int          stall_idx;
    bp_tab = '{'{16'd1, 16'd10, 16'd7, 16'd100},  '{16'd2, 16'd20, 16'd7, 16'd200},
               '{16'd3, 16'd30, 16'd7, 16'd300},  '{16'd4, 16'd1, 16'd9, 16'd1000},
               '{16'd5, 16'd1, 16'd9, 16'd1000},  '{16'd6, 16'd1, 16'd9, 16'd1000},
               '{16'd1, 16'd1, 16'd2, 16'd3},     '{16'd1, 16'd1, 16'd2, 16'd3},
               '{16'd1, 16'd1, 16'd2, 16'd3}};
    stall_idx = (LAT == 2) ? 6 : 5;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    i_line = '0; i2_line = '0; ti_lines = '0;
    model_clear();

    // Reset state
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sums", {sum_I, sum_I2, sum_TI}, 0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Basic window with latency check
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_line(16'd1, 16'd1, 16'd2, 16'd3, stalls_v);
      chk("basic_nostall", stalls_v, 0);
    end
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, LAT);
    @(posedge clk); #1;
    chk("drain_clears_valid", out_valid, 0);

    // Max-value window
    for (int k = 0; k < 3; k++) send_line(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, stalls_v);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: three windows streamed while the consumer is stalled
    out_ready = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (j == stall_idx) begin
        fork
          send_line(bp_tab[j][0], bp_tab[j][1], bp_tab[j][2], bp_tab[j][3], stalls_v);
          begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
          end
        join
        chk("bp_stall", stalls_v, 3);
      end else begin
        send_line(bp_tab[j][0], bp_tab[j][1], bp_tab[j][2], bp_tab[j][3], stalls_v);
        chk("bp_nostall", stalls_v, 0);
      end
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // clr mid-window: partial I=5 lines discarded, beat during clr refused
    send_line(16'd5, 16'd0, 16'd0, 16'd0, stalls_v);
    send_line(16'd5, 16'd0, 16'd0, 16'd0, stalls_v);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
    for (int k = 0; k < 3; k++) send_line(16'd1, 16'd0, 16'd0, 16'd0, stalls_v);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Async reset while a result is held and a window is partial
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_line(16'd1, 16'd1, 16'd2, 16'd3, stalls_v);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sums", {sum_I, sum_I2, sum_TI}, 0);
    chk("async_rst_in_ready", in_ready, 0);
    exp_q.delete();
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) send_line(16'd2, 16'd3, 16'd4, 16'd5, stalls_v);
    in_valid = 1'b0;

    w = 0;
    while (exp_q.size() != 0 && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
